// File: rtl/ysyx_23060191_dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM codes, bus widths, byte merge.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ysyx_23060191_dmem_resp_pkg;

    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_23060191_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 on reset, advances on step.
// Latency: new value visible the cycle after step.
// Backpressure: none; step is a plain enable.
module ysyx_23060191_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output logic [7:0] value
);

    logic [7:0] r_value;

    // Shift left, feeding back the XOR of taps 8, 6, 5 and 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= 8'hA5;
        end else if (step) begin
            r_value <= {r_value[6:0], r_value[7] ^ r_value[5] ^ r_value[4] ^ r_value[3]};
        end
    end

    assign value = r_value;

endmodule

// File: rtl/ysyx_23060191_dmem_resp.sv
// Word-wide data memory with byte-masked stores behind req/rsp valid-ready channels.
// Latency: rsp_valid rises LATENCY edges after the accepting edge (plus lfsr[1:0] with YSYX_23060191_DMEM_RAND_DELAY_EN).
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module ysyx_23060191_dmem_resp
    import ysyx_23060191_dmem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 14,
    parameter int          LATENCY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);

    if (LATENCY > 15 || LATENCY < 0) begin : g_bad_latency
        $error("ysyx_23060191_dmem_resp: LATENCY must be within 0..15");
    end

    dmem_state_e       r_state;
    dmem_state_e       w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_eff_lat;
    logic              r_wen;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_cur_wen;
    logic [31:0]           w_cur_addr;
    logic [DATA_W-1:0]     w_cur_wdata;
    logic [MASK_W-1:0]     w_cur_wmask;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_in_range;

    assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef YSYX_23060191_DMEM_RAND_DELAY_EN
    logic [7:0] w_lfsr;
    logic [4:0] w_lat_sum;

    ysyx_23060191_lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (w_accept),
        .value (w_lfsr)
    );

    assign w_lat_sum = 5'(LATENCY) + {3'b000, w_lfsr[1:0]};
    assign w_eff_lat = w_lat_sum[4] ? {CNT_W{1'b1}} : w_lat_sum[CNT_W-1:0];
`else
    assign w_eff_lat = CNT_W'(LATENCY);
`endif

    // With zero latency the access happens on the accepting edge, before the
    // request registers are loaded, so take the fields straight off the port.
    assign w_cur_wen   = (r_state == ST_IDLE) ? req_wen   : r_wen;
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_cur_wmask = (r_state == ST_IDLE) ? req_wmask : r_wmask;
    assign w_idx       = w_cur_addr[DEPTH_LOG2+1:2];
    assign w_in_range  = ({1'b0, w_cur_addr} >= {1'b0, BASE_ADDR}) &&
                         ({1'b0, w_cur_addr} <  END_ADDR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state; w_enter_resp marks the single edge that performs the access.
    always_comb begin
        w_next_state = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_eff_lat == '0) begin
                        w_next_state = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Counter was loaded with the latency; the last wait cycle is the one holding 1.
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Wait counter and request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_cnt   <= w_eff_lat;
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
        end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Response data is captured once on RESP entry and held, so nothing later can disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_err   <= !w_in_range;
            r_rdata <= (!w_cur_wen && w_in_range) ? r_mem[w_idx] : '0;
        end else if (r_state == ST_RESP && rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    // Array write port; contents survive reset, but no write lands while rst is high.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_cur_wen && w_in_range && !rst) begin
            r_mem[w_idx] <= merge_bytes(r_mem[w_idx], w_cur_wdata, w_cur_wmask);
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060191_dmem_resp.sv
// Directed bench for the data-memory responder: one instance at LATENCY=1, one at LATENCY=5.
// Latency: checks response arrival cycle against the configured latency.
// Backpressure: exercises rsp_ready held low and reset during the wait phase.
module tb_ysyx_23060191_dmem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: LATENCY = 1
    logic        a_rst, a_req_valid, a_req_ready, a_req_wen, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_wmask;
    // Instance B: LATENCY = 5
    logic        b_rst, b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_wmask;

    ysyx_23060191_dmem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(14), .LATENCY(1)) dut (
        .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_wen(a_req_wen), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .req_wmask(a_req_wmask), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    ysyx_23060191_dmem_resp #(.BASE_ADDR(32'h8000_0000), .DEPTH_LOG2(14), .LATENCY(5)) dut5 (
        .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_wen(b_req_wen), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_wmask(b_req_wmask), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic vld, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        if (sel) begin
            b_req_valid = vld; b_req_wen = wen; b_req_addr = addr; b_req_wdata = wdata; b_req_wmask = mask;
        end else begin
            a_req_valid = vld; a_req_wen = wen; a_req_addr = addr; a_req_wdata = wdata; a_req_wmask = mask;
        end
    endtask

    // One full transaction; lat counts cycles from accept to the first rsp_valid.
    task automatic run_req(input bit sel, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        drive(sel, 1'b1, wen, addr, wdata, mask);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        lat = 1;
        while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = sel ? b_rsp_rdata : a_rsp_rdata;
        err   = sel ? b_rsp_err   : a_rsp_err;
        if (sel) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (sel) b_rsp_ready = 1'b0; else a_rsp_ready = 1'b0;
    endtask

    vec_t        vecs [15];
    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        vecs[0]  = '{1'b1, 32'h8000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0010, 32'h0000_AB00, 4'h2, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_ABEF, 1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_ABEF, 1'b0};
        vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h8001_0000, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_FFFC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_FFFE, 32'h1234_0000, 4'hC, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 32'h8000_FFFC, 32'h0000_0000, 4'h0, 32'h1234_A5A5, 1'b0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_ABEF, 1'b0};

        a_rst = 1'b1; b_rst = 1'b1;
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        chk("reset_req_ready",  {31'b0, a_req_ready}, 32'd1);
        chk("reset_rsp_valid",  {31'b0, a_rsp_valid}, 32'd0);
        chk("reset_rsp_rdata",  a_rsp_rdata, 32'd0);
        chk("reset_rsp_err",    {31'b0, a_rsp_err}, 32'd0);
        chk("reset5_req_ready", {31'b0, b_req_ready}, 32'd1);
        chk("reset5_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);

        // Table-driven transactions on the LATENCY=1 instance.
        for (int i = 0; i < 15; i++) begin
            run_req(1'b0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), lat, 32'd2);
        end

        // Backpressure: hold the load response for 10 cycles while a store is offered.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h5555_5555, 4'hF);
        lat = 1;
        while (!a_rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_rsp_valid", i), {31'b0, a_rsp_valid}, 32'd1);
            chk($sformatf("bp%0d_rdata", i), a_rsp_rdata, 32'hDEAD_ABEF);
            chk($sformatf("bp%0d_req_ready", i), {31'b0, a_req_ready}, 32'd0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        chk("bp_after_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
        chk("bp_after_req_ready", {31'b0, a_req_ready}, 32'd1);
        run_req(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        chk("bp_store_not_taken", rd, 32'hDEAD_ABEF);

        // LATENCY=5: known value first, then a store killed by reset in WAIT.
        run_req(1'b1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        chk("lat5_store_latency", lat, 32'd6);
        chk("lat5_store_rdata", rd, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("lat5_in_wait", {31'b0, b_req_ready}, 32'd0);
        @(negedge clk);
        b_rst = 1'b1;
        #1;
        chk("rst_wait_req_ready", {31'b0, b_req_ready}, 32'd1);
        chk("rst_wait_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
        run_req(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
        chk("rst_wait_old_value", rd, 32'hCAFE_F00D);
        chk("rst_wait_load_err", {31'b0, er}, 32'd0);
        chk("rst_wait_load_latency", lat, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
